cgra_wr_buffer: RTL and testbench

Write-back stage directly downstream of the CGRA top. It absorbs 512-bit result lines from the CGRA write port (available_write/req_wr_data/wr_data) into a FIFO. It drains them to the host memory write channel with a valid/ready handshake and sequential addresses. It asserts its own done only after the CGRA reports done and every buffered line has been accepted by memory.

---
 rtl/cgra_wr_buffer_if.sv | 27 ++
 rtl/cgra_wr_buffer.sv | 143 ++++++++++++++
 tb/tb_cgra_wr_buffer.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cgra_wr_buffer_if.sv
// Memory write channel between the CGRA write-back buffer and host memory.
// Valid/ready handshake carrying one full result line per beat.
interface cgra_wr_buffer_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 64
);

  logic              mem_wr_valid;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_ready;

  modport master (
    output mem_wr_valid,
    output mem_wr_addr,
    output mem_wr_data,
    input  mem_wr_ready
  );

  modport slave (
    input  mem_wr_valid,
    input  mem_wr_addr,
    input  mem_wr_data,
    output mem_wr_ready
  );

endinterface

// File: rtl/cgra_wr_buffer.sv
// CGRA write-back buffer: FIFO absorbing CGRA result lines and draining
// them to memory at sequential addresses, with done after full drain.
module cgra_wr_buffer #(
  parameter int DATA_W     = 512,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 64,
  parameter int LINE_BYTES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              available_write,
  input  logic              req_wr_data,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              cgra_done,
  cgra_wr_buffer_if.master  mem,
  output logic [31:0]       lines_written,
  output logic              overflow,
  output logic              done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(LINE_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       lines_q, lines_d;
  logic              ovf_q, ovf_d;

  logic [DATA_W-1:0] fifo_q [DEPTH];

  logic push;
  logic pop;
  logic avail;
  logic valid;

  // Writes only accepted while running; full blocks even with a pop.
  assign avail = (state_q == S_RUN) && (count_q != FULL);
  assign valid = (count_q != '0);
  assign push  = req_wr_data && avail;
  assign pop   = valid && mem.mem_wr_ready;

  assign available_write  = avail;
  assign mem.mem_wr_valid = valid;
  assign mem.mem_wr_addr  = addr_q;
  assign mem.mem_wr_data  = fifo_q[rd_ptr_q];
  assign lines_written    = lines_q;
  assign overflow         = ovf_q;
  assign done             = (state_q == S_DONE);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    lines_d  = lines_q;
    ovf_d    = ovf_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      addr_d   = addr_q + STEP;
      lines_d  = lines_q + 32'd1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if ((state_q == S_RUN) && req_wr_data && !avail) begin
      ovf_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          addr_d  = base_addr;
          lines_d = '0;
          ovf_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (cgra_done) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Finish as soon as the last beat handshakes.
        if (count_d == '0) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      lines_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      lines_q  <= lines_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_cgra_wr_buffer.sv
// Directed self-checking bench for cgra_wr_buffer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cgra_wr_buffer;

  logic         clk;
  logic         rst;
  logic         start;
  logic [63:0]  base_addr;
  logic         available_write;
  logic         req_wr_data;
  logic [511:0] wr_data;
  logic         cgra_done;
  logic [31:0]  lines_written;
  logic         overflow;
  logic         done;
  logic         ready;

  int checks;
  int errors;

  logic [63:0]  q_addr[$];
  logic [511:0] q_data[$];

  cgra_wr_buffer_if #(.DATA_W(512), .ADDR_W(64)) mif ();

  assign mif.mem_wr_ready = ready;

  cgra_wr_buffer #(
    .DATA_W(512),
    .DEPTH(16),
    .ADDR_W(64),
    .LINE_BYTES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .available_write(available_write),
    .req_wr_data(req_wr_data),
    .wr_data(wr_data),
    .cgra_done(cgra_done),
    .mem(mif.master),
    .lines_written(lines_written),
    .overflow(overflow),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] mk(input int k);
    return {16{32'hC0DE0000 + 32'(k)}};
  endfunction

  // Log any handshake of this cycle, then advance to the next cycle.
  task automatic tick();
    if (mif.mem_wr_valid && ready) begin
      q_addr.push_back(mif.mem_wr_addr);
      q_data.push_back(mif.mem_wr_data);
    end
    @(negedge clk);
  endtask

  task automatic do_start(input logic [63:0] b);
    start = 1'b1;
    base_addr = b;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (available_write !== 1'b0) begin
      errors++;
      $display("FAIL rst_avail got %b exp 0", available_write);
    end
    checks++;
    if (mif.mem_wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b exp 0", mif.mem_wr_valid);
    end
    checks++;
    if ({done, overflow} !== 2'b00) begin
      errors++;
      $display("FAIL rst_done_ovf got %b exp 00", {done, overflow});
    end
    checks++;
    if (lines_written !== 32'd0) begin
      errors++;
      $display("FAIL rst_lines got %0d exp 0", lines_written);
    end
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (available_write !== 1'b0) begin
      errors++;
      $display("FAIL idle_avail got %b exp 0", available_write);
    end
  endtask

  task automatic test_basic();
    q_addr.delete();
    q_data.delete();
    ready = 1'b1;
    do_start(64'h1000);
    checks++;
    if (available_write !== 1'b1) begin
      errors++;
      $display("FAIL basic_avail got %b exp 1", available_write);
    end
    req_wr_data = 1'b1;
    wr_data = mk(1);
    tick();
    wr_data = mk(2);
    tick();
    wr_data = mk(3);
    cgra_done = 1'b1;
    tick();
    req_wr_data = 1'b0;
    cgra_done = 1'b0;
    checks++;
    if ({available_write, mif.mem_wr_valid} !== 2'b01) begin
      errors++;
      $display("FAIL basic_flush got %b exp 01",
               {available_write, mif.mem_wr_valid});
    end
    checks++;
    if (mif.mem_wr_addr !== 64'h1080) begin
      errors++;
      $display("FAIL basic_addr_c got %h exp 1080", mif.mem_wr_addr);
    end
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL basic_done got %b exp 1", done);
    end
    checks++;
    if (lines_written !== 32'd3) begin
      errors++;
      $display("FAIL basic_lines got %0d exp 3", lines_written);
    end
    checks++;
    if ({overflow, mif.mem_wr_valid} !== 2'b00) begin
      errors++;
      $display("FAIL basic_ovf_valid got %b exp 00",
               {overflow, mif.mem_wr_valid});
    end
    checks++;
    if (q_addr.size() !== 3) begin
      errors++;
      $display("FAIL basic_count got %0d exp 3", q_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q_addr[i] !== 64'h1000 + 64'(i * 64) || q_data[i] !== mk(1 + i)) begin
          errors++;
          $display("FAIL basic_beat%0d got %h exp %h", i, q_addr[i],
                   64'h1000 + 64'(i * 64));
        end
      end
    end
  endtask

  task automatic test_full_backpressure();
    q_addr.delete();
    q_data.delete();
    ready = 1'b0;
    do_start(64'h2000);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (available_write !== 1'b1) begin
        errors++;
        $display("FAIL fill_avail%0d got %b exp 1", i, available_write);
      end
      req_wr_data = 1'b1;
      wr_data = mk(16 + i);
      tick();
    end
    req_wr_data = 1'b0;
    checks++;
    if (available_write !== 1'b0) begin
      errors++;
      $display("FAIL full_avail got %b exp 0", available_write);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mif.mem_wr_valid !== 1'b1 || mif.mem_wr_addr !== 64'h2000 ||
          mif.mem_wr_data !== mk(16)) begin
        errors++;
        $display("FAIL hold%0d got v=%b a=%h exp v=1 a=2000", i,
                 mif.mem_wr_valid, mif.mem_wr_addr);
      end
      tick();
    end
  endtask

  task automatic test_overflow();
    req_wr_data = 1'b1;
    wr_data = mk(99);
    tick();
    req_wr_data = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got %b exp 1", overflow);
    end
    checks++;
    if (available_write !== 1'b0 || mif.mem_wr_data !== mk(16)) begin
      errors++;
      $display("FAIL ovf_fifo got avail=%b exp 0", available_write);
    end
    tick();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky got %b exp 1", overflow);
    end
    ready = 1'b1;
    for (int i = 0; i < 40 && mif.mem_wr_valid; i++) tick();
    checks++;
    if (q_addr.size() !== 16) begin
      errors++;
      $display("FAIL drain_count got %0d exp 16", q_addr.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (q_addr[i] !== 64'h2000 + 64'(i * 64) || q_data[i] !== mk(16 + i)) begin
          errors++;
          $display("FAIL drain_beat%0d got %h exp %h", i, q_addr[i],
                   64'h2000 + 64'(i * 64));
        end
      end
    end
    checks++;
    if (lines_written !== 32'd16 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL drain_lines got %0d ovf=%b exp 16 ovf=1",
               lines_written, overflow);
    end
  endtask

  task automatic test_simul_push_pop();
    q_addr.delete();
    q_data.delete();
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_wr_data = 1'b1;
      wr_data = mk(40 + i);
      tick();
    end
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = mk(44 + i);
      checks++;
      if (available_write !== 1'b1) begin
        errors++;
        $display("FAIL sim_avail%0d got %b exp 1", i, available_write);
      end
      tick();
    end
    req_wr_data = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mif.mem_wr_valid !== 1'b1) begin
        errors++;
        $display("FAIL sim_tail%0d got %b exp 1", i, mif.mem_wr_valid);
      end
      tick();
    end
    checks++;
    if (mif.mem_wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL sim_empty got %b exp 0", mif.mem_wr_valid);
    end
    checks++;
    if (q_addr.size() !== 14) begin
      errors++;
      $display("FAIL sim_count got %0d exp 14", q_addr.size());
    end else begin
      for (int i = 0; i < 14; i++) begin
        checks++;
        if (q_addr[i] !== 64'h2400 + 64'(i * 64) || q_data[i] !== mk(40 + i)) begin
          errors++;
          $display("FAIL sim_beat%0d got %h exp %h", i, q_addr[i],
                   64'h2400 + 64'(i * 64));
        end
      end
    end
    checks++;
    if (lines_written !== 32'd30) begin
      errors++;
      $display("FAIL sim_lines got %0d exp 30", lines_written);
    end
    cgra_done = 1'b1;
    tick();
    cgra_done = 1'b0;
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL sim_done got %b exp 1", done);
    end
  endtask

  task automatic test_early_done();
    q_addr.delete();
    q_data.delete();
    ready = 1'b0;
    do_start(64'h3000);
    checks++;
    if ({overflow, done} !== 2'b00) begin
      errors++;
      $display("FAIL ed_start got %b exp 00", {overflow, done});
    end
    for (int i = 0; i < 5; i++) begin
      req_wr_data = 1'b1;
      wr_data = mk(60 + i);
      tick();
    end
    req_wr_data = 1'b0;
    cgra_done = 1'b1;
    ready = 1'b1;
    checks++;
    if (available_write !== 1'b1) begin
      errors++;
      $display("FAIL ed_run_avail got %b exp 1", available_write);
    end
    tick();
    cgra_done = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      ready = (k % 2 == 0);
      req_wr_data = (k == 1);
      wr_data = mk(77);
      checks++;
      if ({available_write, done} !== 2'b00) begin
        errors++;
        $display("FAIL ed_flush%0d got %b exp 00", k, {available_write, done});
      end
      tick();
    end
    req_wr_data = 1'b0;
    checks++;
    if (done !== 1'b1 || lines_written !== 32'd5) begin
      errors++;
      $display("FAIL ed_done got %b lines %0d exp 1 lines 5", done, lines_written);
    end
    checks++;
    if ({overflow, mif.mem_wr_valid} !== 2'b00) begin
      errors++;
      $display("FAIL ed_ovf_valid got %b exp 00", {overflow, mif.mem_wr_valid});
    end
    checks++;
    if (q_addr.size() !== 5) begin
      errors++;
      $display("FAIL ed_count got %0d exp 5", q_addr.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (q_addr[i] !== 64'h3000 + 64'(i * 64) || q_data[i] !== mk(60 + i)) begin
          errors++;
          $display("FAIL ed_beat%0d got %h exp %h", i, q_addr[i],
                   64'h3000 + 64'(i * 64));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    q_addr.delete();
    q_data.delete();
    ready = 1'b0;
    do_start(64'h5000);
    for (int i = 0; i < 3; i++) begin
      req_wr_data = 1'b1;
      wr_data = mk(80 + i);
      tick();
    end
    req_wr_data = 1'b0;
    cgra_done = 1'b1;
    tick();
    cgra_done = 1'b0;
    checks++;
    if ({available_write, mif.mem_wr_valid} !== 2'b01) begin
      errors++;
      $display("FAIL ar_flush got %b exp 01", {available_write, mif.mem_wr_valid});
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({mif.mem_wr_valid, done, available_write} !== 3'b000) begin
      errors++;
      $display("FAIL ar_async got %b exp 000",
               {mif.mem_wr_valid, done, available_write});
    end
    checks++;
    if (lines_written !== 32'd0) begin
      errors++;
      $display("FAIL ar_lines got %0d exp 0", lines_written);
    end
    #1 rst = 1'b1;
    @(negedge clk);
    req_wr_data = 1'b1;
    wr_data = mk(83);
    tick();
    req_wr_data = 1'b0;
    checks++;
    if ({mif.mem_wr_valid, overflow, available_write} !== 3'b000) begin
      errors++;
      $display("FAIL ar_idle got %b exp 000",
               {mif.mem_wr_valid, overflow, available_write});
    end
    ready = 1'b1;
    do_start(64'h0);
    checks++;
    if (available_write !== 1'b1) begin
      errors++;
      $display("FAIL ar_restart got %b exp 1", available_write);
    end
    req_wr_data = 1'b1;
    wr_data = mk(90);
    tick();
    wr_data = mk(91);
    cgra_done = 1'b1;
    tick();
    req_wr_data = 1'b0;
    cgra_done = 1'b0;
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL ar_done got %b exp 1", done);
    end
    checks++;
    if (q_addr.size() !== 2) begin
      errors++;
      $display("FAIL ar_count got %0d exp 2", q_addr.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (q_addr[i] !== 64'(i * 64) || q_data[i] !== mk(90 + i)) begin
          errors++;
          $display("FAIL ar_beat%0d got %h exp %h", i, q_addr[i], 64'(i * 64));
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    start = 1'b0;
    base_addr = '0;
    req_wr_data = 1'b0;
    wr_data = '0;
    cgra_done = 1'b0;
    ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_basic();
    test_full_backpressure();
    test_overflow();
    test_simul_push_pop();
    test_early_done();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
